// File: rtl/utf8_stream_decoder.sv
// utf8_stream_decoder
//
// Streaming UTF-8 decoder with valid/ready handshakes on both sides. Each
// well-formed sequence yields one scalar value. Each maximal ill-formed
// subpart yields REPL with out_err set. A continuation byte outside the
// legal range for its position is not consumed. Instead, the prefix held so
// far is reported as an error, and that byte is re-evaluated as a lead on
// the following cycle.
//
// Parameters
//   STRICT    1: reject surrogates and values above U+10FFFF; 0: accept them
//   REPL      code point emitted for every error
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   in_valid  byte available            in_ready  byte accepted this edge
//   in_data   byte                      in_last   final byte of the stream
//   out_valid result held               out_ready result consumed this edge
//   out_cp    scalar value or REPL      out_err   result is an error
//   out_len   bytes covered (1-4)       out_last  last result of the stream
//   err_count saturating error count since reset

module utf8_stream_decoder #(
  parameter bit          STRICT = 1'b1,
  parameter logic [20:0] REPL   = 21'h00FFFD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] out_cp,
  output logic        out_err,
  output logic [2:0]  out_len,
  output logic        out_last,
  output logic [15:0] err_count
);

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_t;

  localparam logic [7:0] CONT_LO = 8'h80;
  localparam logic [7:0] CONT_HI = 8'hBF;

  // Sequence state
  state_t      state_q, state_d;
  logic [1:0]  need_q, need_d;
  logic [20:0] acc_q, acc_d;
  logic [2:0]  len_q, len_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;

  // Output register
  logic        out_valid_q, out_valid_d;
  logic [20:0] out_cp_q, out_cp_d;
  logic        out_err_q, out_err_d;
  logic [2:0]  out_len_q, out_len_d;
  logic        out_last_q, out_last_d;
  logic [15:0] err_count_q, err_count_d;

  // Handshake
  logic slot_free;
  logic in_range;
  logic reject;
  logic accept;

  assign slot_free = ~out_valid_q | out_ready;
  assign in_range  = (in_data >= lo_q) && (in_data <= hi_q);
  assign reject    = (state_q == S_ACC) && in_valid && !in_range;
  assign in_ready  = slot_free && !reject;
  assign accept    = in_valid && in_ready;

  // Lead-byte classification: continuation count (0 = not a multi-byte
  // lead), payload bits, and the legal range of the first continuation byte.
  logic [1:0]  lead_need;
  logic [20:0] lead_acc;
  logic [7:0]  lead_lo;
  logic [7:0]  lead_hi;

  always_comb begin
    lead_need = 2'd0;
    lead_acc  = '0;
    lead_lo   = CONT_LO;
    lead_hi   = CONT_HI;
    if (in_data >= 8'hC2 && in_data <= 8'hDF) begin
      lead_need = 2'd1;
      lead_acc  = {16'd0, in_data[4:0]};
    end else if (in_data[7:4] == 4'hE) begin
      lead_need = 2'd2;
      lead_acc  = {17'd0, in_data[3:0]};
      if (in_data == 8'hE0) begin
        lead_lo = 8'hA0;
      end
      if (in_data == 8'hED && STRICT) begin
        lead_hi = 8'h9F;
      end
    end else if ((in_data >= 8'hF0 && in_data <= 8'hF4) ||
                 (!STRICT && in_data >= 8'hF5 && in_data <= 8'hF7)) begin
      lead_need = 2'd3;
      lead_acc  = {18'd0, in_data[2:0]};
      if (in_data == 8'hF0) begin
        lead_lo = 8'h90;
      end
      if (in_data == 8'hF4 && STRICT) begin
        lead_hi = 8'h8F;
      end
    end
  end

  // Next-state and emission logic
  logic        emit;
  logic [20:0] emit_cp;
  logic        emit_err;
  logic [2:0]  emit_len;
  logic        emit_last;
  logic [20:0] acc_shift;
  logic [2:0]  len_inc;

  assign acc_shift = {acc_q[14:0], in_data[5:0]};
  assign len_inc   = len_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    need_d    = need_q;
    acc_d     = acc_q;
    len_d     = len_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    emit      = 1'b0;
    emit_cp   = '0;
    emit_err  = 1'b0;
    emit_len  = '0;
    emit_last = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!in_data[7]) begin
            emit      = 1'b1;
            emit_cp   = {13'd0, in_data};
            emit_len  = 3'd1;
            emit_last = in_last;
          end else if (lead_need == 2'd0 || in_last) begin
            // Invalid lead, or a valid lead that ends the stream.
            emit      = 1'b1;
            emit_cp   = REPL;
            emit_err  = 1'b1;
            emit_len  = 3'd1;
            emit_last = in_last;
          end else begin
            state_d = S_ACC;
            need_d  = lead_need;
            acc_d   = lead_acc;
            len_d   = 3'd1;
            lo_d    = lead_lo;
            hi_d    = lead_hi;
          end
        end
      end

      S_ACC: begin
        if (accept) begin
          lo_d = CONT_LO;
          hi_d = CONT_HI;
          if (need_q == 2'd1) begin
            emit      = 1'b1;
            emit_cp   = acc_shift;
            emit_len  = len_inc;
            emit_last = in_last;
            state_d   = S_IDLE;
            need_d    = 2'd0;
            acc_d     = '0;
            len_d     = '0;
          end else if (in_last) begin
            emit      = 1'b1;
            emit_cp   = REPL;
            emit_err  = 1'b1;
            emit_len  = len_inc;
            emit_last = 1'b1;
            state_d   = S_IDLE;
            need_d    = 2'd0;
            acc_d     = '0;
            len_d     = '0;
          end else begin
            need_d = need_q - 2'd1;
            acc_d  = acc_shift;
            len_d  = len_inc;
          end
        end else if (reject && slot_free) begin
          // The offending byte stays on the input; its in_last belongs to
          // its own re-evaluation, so the prefix error never carries it.
          emit     = 1'b1;
          emit_cp  = REPL;
          emit_err = 1'b1;
          emit_len = len_q;
          state_d  = S_IDLE;
          need_d   = 2'd0;
          acc_d    = '0;
          len_d    = '0;
          lo_d     = CONT_LO;
          hi_d     = CONT_HI;
        end
      end

      default: begin
        state_d = S_IDLE;
        need_d  = 2'd0;
      end
    endcase
  end

  // Output register: every emission path above already implies slot_free.
  always_comb begin
    out_valid_d = out_valid_q;
    out_cp_d    = out_cp_q;
    out_err_d   = out_err_q;
    out_len_d   = out_len_q;
    out_last_d  = out_last_q;
    err_count_d = err_count_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_cp_d    = emit_cp;
      out_err_d   = emit_err;
      out_len_d   = emit_len;
      out_last_d  = emit_last;
      if (emit_err && err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      need_q      <= 2'd0;
      acc_q       <= '0;
      len_q       <= '0;
      lo_q        <= CONT_LO;
      hi_q        <= CONT_HI;
      out_valid_q <= 1'b0;
      out_cp_q    <= '0;
      out_err_q   <= 1'b0;
      out_len_q   <= '0;
      out_last_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      need_q      <= need_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      out_cp_q    <= out_cp_d;
      out_err_q   <= out_err_d;
      out_len_q   <= out_len_d;
      out_last_q  <= out_last_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cp    = out_cp_q;
  assign out_err   = out_err_q;
  assign out_len   = out_len_q;
  assign out_last  = out_last_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Testbench for utf8_stream_decoder. Two instances share the clock and
// reset: index 1 is built with STRICT=1, index 0 with STRICT=0. Directed
// scenarios use constant expectations; randomized streams are checked
// against a byte-array reference decoder.

module tb_utf8_stream_decoder;

  typedef struct packed {
    logic [20:0] cp;
    logic        err;
    logic [2:0]  len;
    logic        last;
  } res_t;

  localparam logic [20:0] REPL = 21'h00FFFD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_data   [2];
  logic        in_last   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [20:0] out_cp    [2];
  logic        out_err   [2];
  logic [2:0]  out_len   [2];
  logic        out_last  [2];
  logic [15:0] err_count [2];

  utf8_stream_decoder #(.STRICT(1'b1), .REPL(REPL)) u_strict (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_cp(out_cp[1]), .out_err(out_err[1]),
    .out_len(out_len[1]), .out_last(out_last[1]), .err_count(err_count[1])
  );

  utf8_stream_decoder #(.STRICT(1'b0), .REPL(REPL)) u_lax (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_cp(out_cp[0]), .out_err(out_err[0]),
    .out_len(out_len[0]), .out_last(out_last[0]), .err_count(err_count[0])
  );

  int tests = 0;
  int fails = 0;
  int ecount [2];
  int stall_cnt;
  bit rand_hs;

  logic [7:0] stim_d[$];
  bit         stim_l[$];
  res_t       exp_q[$];
  res_t       got_q[$];

  function automatic res_t mk(input logic [20:0] cp, input logic err, input logic [2:0] len,
                              input logic last);
    res_t r;
    r.cp   = cp;
    r.err  = err;
    r.len  = len;
    r.last = last;
    return r;
  endfunction

  task automatic load(input logic [7:0] b, input bit l);
    stim_d.push_back(b);
    stim_l.push_back(l);
  endtask

  task automatic clear_stim();
    stim_d.delete();
    stim_l.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_last[s]   = 1'b0;
      in_data[s]   = 8'h00;
      out_ready[s] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    ecount[0] = 0;
    ecount[1] = 0;
  endtask

  // Drives stim_d/stim_l into instance s and collects exp_q.size() results.
  task automatic run_stream(input int s);
    int n;
    int ne;
    n  = stim_d.size();
    ne = exp_q.size();
    got_q.delete();
    stall_cnt = 0;
    fork
      begin : drv
        int i;
        int cyc;
        i   = 0;
        cyc = 0;
        while (i < n && cyc < 3000) begin
          in_valid[s] = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
          in_data[s]  = stim_d[i];
          in_last[s]  = stim_l[i];
          @(negedge clk);
          if (in_valid[s] && !in_ready[s]) stall_cnt++;
          if (in_valid[s] && in_ready[s]) i++;
          @(posedge clk);
          #1;
          cyc++;
        end
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
      end
      begin : mon
        int cyc;
        cyc = 0;
        while (got_q.size() < ne && cyc < 3000) begin
          out_ready[s] = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
          @(negedge clk);
          if (out_valid[s] && out_ready[s])
            got_q.push_back(mk(out_cp[s], out_err[s], out_len[s], out_last[s]));
          @(posedge clk);
          #1;
          cyc++;
        end
        out_ready[s] = 1'b1;
      end
    join
  endtask

  // Reference decoder over the whole byte array: maximal-subpart rules,
  // with a rejected continuation byte left in place for the next lead.
  task automatic model(input bit strict);
    int i;
    int n;
    int need;
    int k;
    int cp;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] lo;
    logic [7:0] hi;
    bit done;
    exp_q.delete();
    n = stim_d.size();
    i = 0;
    while (i < n) begin
      b    = stim_d[i];
      lo   = 8'h80;
      hi   = 8'hBF;
      need = 0;
      cp   = 0;
      if (b < 8'h80) begin
        exp_q.push_back(mk(21'(b), 1'b0, 3'd1, stim_l[i]));
        i++;
        continue;
      end
      if (b >= 8'hC2 && b <= 8'hDF) begin
        need = 1;
        cp   = int'(b & 8'h1F);
      end else if (b >= 8'hE0 && b <= 8'hEF) begin
        need = 2;
        cp   = int'(b & 8'h0F);
        if (b == 8'hE0) lo = 8'hA0;
        if (b == 8'hED && strict) hi = 8'h9F;
      end else if (b >= 8'hF0 && b <= (strict ? 8'hF4 : 8'hF7)) begin
        need = 3;
        cp   = int'(b & 8'h07);
        if (b == 8'hF0) lo = 8'h90;
        if (b == 8'hF4 && strict) hi = 8'h8F;
      end
      if (need == 0 || stim_l[i]) begin
        exp_q.push_back(mk(REPL, 1'b1, 3'd1, stim_l[i]));
        i++;
        continue;
      end
      k    = 1;
      done = 1'b0;
      while (!done) begin
        if (i + k >= n) begin
          i    = n;
          done = 1'b1;
        end else begin
          c = stim_d[i + k];
          if (c < lo || c > hi) begin
            exp_q.push_back(mk(REPL, 1'b1, 3'(k), 1'b0));
            i    = i + k;
            done = 1'b1;
          end else begin
            cp = cp * 64 + int'(c - 8'h80);
            lo = 8'h80;
            hi = 8'hBF;
            if (k == need) begin
              exp_q.push_back(mk(21'(cp), 1'b0, 3'(k + 1), stim_l[i + k]));
              i    = i + k + 1;
              done = 1'b1;
            end else if (stim_l[i + k]) begin
              exp_q.push_back(mk(REPL, 1'b1, 3'(k + 1), 1'b1));
              i    = i + k + 1;
              done = 1'b1;
            end else begin
              k++;
            end
          end
        end
      end
    end
  endtask

  task automatic gen_stream(input int nchars);
    int kind;
    int cp;
    clear_stim();
    repeat (nchars) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2: load(8'($urandom_range(0, 127)), 1'b0);
        3: begin
          cp = int'($urandom_range(32'h80, 32'h7FF));
          load(8'(32'hC0 | (cp >> 6)), 1'b0);
          load(8'(32'h80 | (cp & 63)), 1'b0);
        end
        4: begin
          cp = int'($urandom_range(32'h800, 32'hFFFF));
          load(8'(32'hE0 | (cp >> 12)), 1'b0);
          load(8'(32'h80 | ((cp >> 6) & 63)), 1'b0);
          load(8'(32'h80 | (cp & 63)), 1'b0);
        end
        5: begin
          cp = int'($urandom_range(32'h10000, 32'h1FFFFF));
          load(8'(32'hF0 | (cp >> 18)), 1'b0);
          load(8'(32'h80 | ((cp >> 12) & 63)), 1'b0);
          load(8'(32'h80 | ((cp >> 6) & 63)), 1'b0);
          load(8'(32'h80 | (cp & 63)), 1'b0);
        end
        6: begin
          cp = int'($urandom_range(32'h800, 32'hFFFF));
          load(8'(32'hE0 | (cp >> 12)), 1'b0);
          load(8'(32'h80 | ((cp >> 6) & 63)), 1'b0);
        end
        7, 8: load(8'($urandom_range(0, 255)), 1'b0);
        default: load(8'($urandom_range(128, 255)), 1'b0);
      endcase
    end
    for (int j = 0; j < stim_l.size(); j++) stim_l[j] = ($urandom_range(0, 11) == 0);
    stim_l[stim_l.size() - 1] = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      tests++;
      if ({out_valid[s], out_cp[s], out_err[s], out_len[s], out_last[s], err_count[s], in_ready[s]}
          !== {1'b0, 21'h0, 1'b0, 3'h0, 1'b0, 16'h0, 1'b1}) begin
        fails++;
        $display("FAIL reset_async[%0d]: got v=%b cp=%h e=%b len=%0d l=%b cnt=%0d rdy=%b, expected all zero with rdy=1",
                 s, out_valid[s], out_cp[s], out_err[s], out_len[s], out_last[s], err_count[s], in_ready[s]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      tests++;
      if ({out_valid[s], err_count[s], in_ready[s]} !== {1'b0, 16'h0, 1'b1}) begin
        fails++;
        $display("FAIL reset_release[%0d]: got v=%b cnt=%0d rdy=%b, expected v=0 cnt=0 rdy=1",
                 s, out_valid[s], err_count[s], in_ready[s]);
      end
    end
  endtask

  task automatic test_valid_chars();
    apply_reset();
    rand_hs = 1'b0;
    clear_stim();
    load(8'h41, 1'b0);
    load(8'hE2, 1'b0); load(8'h82, 1'b0); load(8'hAC, 1'b0);
    load(8'hF0, 1'b0); load(8'h9F, 1'b0); load(8'h98, 1'b0); load(8'h80, 1'b1);
    exp_q.push_back(mk(21'h41, 1'b0, 3'd1, 1'b0));
    exp_q.push_back(mk(21'h20AC, 1'b0, 3'd3, 1'b0));
    exp_q.push_back(mk(21'h1F600, 1'b0, 3'd4, 1'b1));
    run_stream(1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL valid_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      tests++;
      if (got_q[j] !== exp_q[j]) begin
        fails++;
        $display("FAIL valid_res[%0d]: got cp=%h err=%b len=%0d last=%b, expected cp=%h err=%b len=%0d last=%b",
                 j, got_q[j].cp, got_q[j].err, got_q[j].len, got_q[j].last,
                 exp_q[j].cp, exp_q[j].err, exp_q[j].len, exp_q[j].last);
      end
    end
    tests++;
    if (err_count[1] !== 16'd0) begin
      fails++;
      $display("FAIL valid_errcount: got %0d, expected 0", err_count[1]);
    end
  endtask

  task automatic test_invalid_bytes();
    apply_reset();
    rand_hs = 1'b0;
    clear_stim();
    load(8'hC0, 1'b0); load(8'h80, 1'b0); load(8'hFF, 1'b1);
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b1));
    run_stream(1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL invalid_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      tests++;
      if (got_q[j] !== exp_q[j]) begin
        fails++;
        $display("FAIL invalid_res[%0d]: got cp=%h err=%b len=%0d last=%b, expected cp=%h err=%b len=%0d last=%b",
                 j, got_q[j].cp, got_q[j].err, got_q[j].len, got_q[j].last,
                 exp_q[j].cp, exp_q[j].err, exp_q[j].len, exp_q[j].last);
      end
    end
    tests++;
    if (err_count[1] !== 16'd3) begin
      fails++;
      $display("FAIL invalid_errcount: got %0d, expected 3", err_count[1]);
    end
  endtask

  task automatic test_reject();
    apply_reset();
    rand_hs = 1'b0;
    clear_stim();
    load(8'hE2, 1'b0); load(8'h82, 1'b0); load(8'h41, 1'b1);
    exp_q.push_back(mk(REPL, 1'b1, 3'd2, 1'b0));
    exp_q.push_back(mk(21'h41, 1'b0, 3'd1, 1'b1));
    run_stream(1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL reject_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      tests++;
      if (got_q[j] !== exp_q[j]) begin
        fails++;
        $display("FAIL reject_res[%0d]: got cp=%h err=%b len=%0d last=%b, expected cp=%h err=%b len=%0d last=%b",
                 j, got_q[j].cp, got_q[j].err, got_q[j].len, got_q[j].last,
                 exp_q[j].cp, exp_q[j].err, exp_q[j].len, exp_q[j].last);
      end
    end
    tests++;
    if (stall_cnt != 1) begin
      fails++;
      $display("FAIL reject_stall: in_ready low for %0d cycles, expected 1", stall_cnt);
    end
  endtask

  task automatic test_strict();
    apply_reset();
    rand_hs = 1'b0;
    for (int s = 1; s >= 0; s--) begin
      clear_stim();
      load(8'hED, 1'b0); load(8'hA0, 1'b0); load(8'h80, 1'b1);
      if (s == 1) begin
        exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
        exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
        exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b1));
      end else begin
        exp_q.push_back(mk(21'h0D800, 1'b0, 3'd3, 1'b1));
      end
      run_stream(s);
      tests++;
      if (got_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL surrogate_count[%0d]: got %0d results, expected %0d", s, got_q.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
        tests++;
        if (got_q[j] !== exp_q[j]) begin
          fails++;
          $display("FAIL surrogate_res[%0d][%0d]: got cp=%h err=%b len=%0d last=%b, expected cp=%h err=%b len=%0d last=%b",
                   s, j, got_q[j].cp, got_q[j].err, got_q[j].len, got_q[j].last,
                   exp_q[j].cp, exp_q[j].err, exp_q[j].len, exp_q[j].last);
        end
      end
    end
    clear_stim();
    load(8'hF4, 1'b0); load(8'h90, 1'b0); load(8'h80, 1'b0); load(8'h80, 1'b1);
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b0));
    exp_q.push_back(mk(REPL, 1'b1, 3'd1, 1'b1));
    run_stream(1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL above_max_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      tests++;
      if (got_q[j] !== exp_q[j]) begin
        fails++;
        $display("FAIL above_max_res[%0d]: got cp=%h err=%b len=%0d last=%b, expected cp=%h err=%b len=%0d last=%b",
                 j, got_q[j].cp, got_q[j].err, got_q[j].len, got_q[j].last,
                 exp_q[j].cp, exp_q[j].err, exp_q[j].len, exp_q[j].last);
      end
    end
    tests++;
    if (err_count[1] !== 16'd7 || err_count[0] !== 16'd0) begin
      fails++;
      $display("FAIL strict_errcount: got strict=%0d lax=%0d, expected strict=7 lax=0", err_count[1], err_count[0]);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h41;
    in_last[1]   = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready[1] !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_ready: got in_ready=%b, expected 1", in_ready[1]);
    end
    @(posedge clk);
    #1;
    in_data[1] = 8'h42;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({out_valid[1], out_cp[1], out_len[1], in_ready[1]} !== {1'b1, 21'h41, 3'd1, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b cp=%h len=%0d rdy=%b, expected v=1 cp=41 len=1 rdy=0",
                 c, out_valid[1], out_cp[1], out_len[1], in_ready[1]);
      end
      @(posedge clk);
      #1;
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_cp[1], in_ready[1]} !== {21'h41, 1'b1}) begin
      fails++;
      $display("FAIL bp_release: got cp=%h rdy=%b, expected cp=41 rdy=1", out_cp[1], in_ready[1]);
    end
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid[1], out_cp[1], out_err[1]} !== {1'b1, 21'h42, 1'b0}) begin
      fails++;
      $display("FAIL bp_next: got v=%b cp=%h err=%b, expected v=1 cp=42 err=0", out_valid[1], out_cp[1], out_err[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_last_and_reset();
    apply_reset();
    rand_hs = 1'b0;
    clear_stim();
    load(8'hE2, 1'b0); load(8'h82, 1'b1);
    exp_q.push_back(mk(REPL, 1'b1, 3'd2, 1'b1));
    run_stream(1);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL last_prefix: got %0d results (first cp=%h err=%b len=%0d last=%b), expected 1 result cp=fffd err=1 len=2 last=1",
               got_q.size(), got_q.size() > 0 ? got_q[0].cp : 21'h0, got_q.size() > 0 ? got_q[0].err : 1'b0,
               got_q.size() > 0 ? got_q[0].len : 3'd0, got_q.size() > 0 ? got_q[0].last : 1'b0);
    end
    // Pending output discarded by reset
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h33;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({out_valid[1], err_count[1]} !== {1'b0, 16'd0}) begin
      fails++;
      $display("FAIL reset_pending: got v=%b cnt=%0d, expected v=0 cnt=0", out_valid[1], err_count[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    // Partial sequence discarded by reset
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hE2;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid[1] !== 1'b0) begin
      fails++;
      $display("FAIL reset_partial: got out_valid=%b, expected 0", out_valid[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_stim();
    load(8'h41, 1'b1);
    exp_q.push_back(mk(21'h41, 1'b0, 3'd1, 1'b1));
    run_stream(1);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || err_count[1] !== 16'd0) begin
      fails++;
      $display("FAIL reset_then_ascii: got %0d results (first cp=%h err=%b) cnt=%0d, expected 1 result cp=41 err=0 cnt=0",
               got_q.size(), got_q.size() > 0 ? got_q[0].cp : 21'h0, got_q.size() > 0 ? got_q[0].err : 1'b0,
               err_count[1]);
    end
  endtask

  task automatic test_random();
    int nerr;
    apply_reset();
    rand_hs = 1'b1;
    for (int t = 0; t < 14; t++) begin
      gen_stream(int'($urandom_range(8, 24)));
      for (int s = 1; s >= 0; s--) begin
        model(s == 1);
        run_stream(s);
        nerr = 0;
        for (int j = 0; j < exp_q.size(); j++) if (exp_q[j].err) nerr++;
        ecount[s] += nerr;
        tests++;
        if (got_q.size() != exp_q.size()) begin
          fails++;
          $display("FAIL rand_count[%0d][%0d]: got %0d results, expected %0d", t, s, got_q.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
          tests++;
          if (got_q[j] !== exp_q[j]) begin
            fails++;
            $display("FAIL rand_res[%0d][%0d][%0d]: got cp=%h err=%b len=%0d last=%b, expected cp=%h err=%b len=%0d last=%b",
                     t, s, j, got_q[j].cp, got_q[j].err, got_q[j].len, got_q[j].last,
                     exp_q[j].cp, exp_q[j].err, exp_q[j].len, exp_q[j].last);
          end
        end
        tests++;
        if (err_count[s] !== 16'(ecount[s])) begin
          fails++;
          $display("FAIL rand_errcount[%0d][%0d]: got %0d, expected %0d", t, s, err_count[s], ecount[s]);
        end
      end
    end
    rand_hs = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_last[s]   = 1'b0;
      in_data[s]   = 8'h00;
      out_ready[s] = 1'b1;
      ecount[s]    = 0;
    end
    rand_hs = 1'b0;
    #2;
    rst = 1'b0;
    test_reset();
    test_valid_chars();
    test_invalid_bytes();
    test_reject();
    test_strict();
    test_backpressure();
    test_last_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/utf8_stream_decoder.md
# utf8_stream_decoder

Synchronous streaming UTF-8 decoder: accepts a byte stream over a valid/ready handshake and emits one Unicode scalar value per well-formed sequence, or U+FFFD with an error flag per maximal ill-formed subpart. It is the single-clock, back-pressured receive-side counterpart to the strobe-driven `hardware_utf8` encoder. It sits between a byte-oriented I/O channel and character-level consumers.

## Interface
- `STRICT`, 1 — 1: reject surrogates (U+D800–DFFF) and values above U+10FFFF; 0: accept them.
- `REPL`, 21'h00FFFD — code point emitted on `out_cp` for every error.
- `clk` in 1 — the single clock; all state updates on rising edge.
- `rst` in 1 — reset is asynchronous and active-low; clears all state.
- `in_valid` in 1 — byte available.
- `in_ready` out 1 — byte accepted when `in_valid & in_ready` at a rising edge.
- `in_data` in 8 — byte.
- `in_last` in 1 — byte is the final byte of the stream.
- `out_valid` out 1 — `out_cp`/`out_err`/`out_len`/`out_last` hold a result.
- `out_ready` in 1 — result consumed when `out_valid & out_ready`.
- `out_cp` out 21 — decoded scalar value, or `REPL` on error.
- `out_err` out 1 — result is an error substitution.
- `out_len` out 3 — bytes covered by this result (1–4).
- `out_last` out 1 — result is the last result of the stream.
- `err_count` out 16 — errors emitted since reset; saturates at 16'hFFFF.

## Operation
- State: `need` (0–3 continuation bytes remaining), `acc` [20:0], `len` [2:0], `lo`/`hi` (legal range for the next continuation byte), plus an output register. `need==0` is IDLE; otherwise ACC.
- IDLE, byte b accepted:
  - 00–7F: emit b, len 1.
  - C2–DF: need=1, acc=b[4:0], range 80–BF.
  - E0: need=2, range A0–BF. ED: need=2, range 80–9F if STRICT, else 80–BF. Other E1–EF: range 80–BF.
  - F0: need=3, range 90–BF. F4: range 80–8F if STRICT, else 80–BF. F1–F3: range 80–BF. F5–F7: accepted as leads only when STRICT=0 (range 80–BF).
  - 80–BF, C0, C1, F8–FF, and F5–F7 when STRICT=1: emit error, len 1.
- ACC, byte b in [lo,hi]: consume; acc={acc,b[5:0]}, len+1, need-1, range resets to 80–BF. When need reaches 0, emit acc.
- ACC, byte outside [lo,hi]: do NOT consume (`in_ready`=0). Emit an error with len = bytes already held, return to IDLE. The same byte is then re-evaluated as a lead on the next cycle.
- `in_last` on a consumed byte that leaves need>0: emit an error for the held prefix with `out_last`=1 in the same cycle; return to IDLE. `in_last` on a byte that completes or errors a sequence: that result carries `out_last`=1. A rejected (unconsumed) byte's `in_last` applies to its later re-evaluation, not to the prefix error.
- Every emitted error increments `err_count` (saturating).

## Timing
- Reset values: `out_valid`=0, `out_cp`=0, `out_err`=0, `out_len`=0, `out_last`=0, `err_count`=0, state IDLE. `in_ready`=1 after reset.
- Reset asserted mid-sequence discards partial state and any pending output immediately, with no output emitted.
- Output is registered. `out_valid` rises on the edge that accepts the final byte, or on the edge of the prefix-error decision; latency is 1 cycle.
- `in_ready` = slot_free & ~(ACC & in_valid & in_data∉[lo,hi]), where slot_free = ~out_valid | out_ready. This is combinational from `out_ready`, `in_valid`, and `in_data`.
- Throughput is 1 byte/cycle with `out_ready` held high; 1 result/cycle for ASCII.
- While `out_valid & ~out_ready`, all output fields hold stable and no byte is consumed.

## Test plan
- 41, then E2 82 AC, then F0 9F 98 80, `out_ready`=1 -> results 0x41/len1, 0x20AC/len3, 0x1F600/len4; `out_err`=0; `err_count`=0.
- C0 80 FF -> three results: FFFD/err/len1 each; `err_count`=3.
- E2 82 41 -> FFFD/err/len2, then 0x41/len1; `in_ready` low for exactly one cycle while 41 is presented.
- STRICT=1: ED A0 80 -> FFFD len1, FFFD len1, FFFD len1. STRICT=0: same bytes -> 0xD800/len3, no error. STRICT=1: F4 90 80 80 -> four len1 errors.
- `out_ready` low 3 cycles after 0x41 result -> output held, `in_ready`=0, next byte is not consumed until release.
- E2 82 with `in_last` on 82 -> FFFD/err/len2/`out_last`=1. Assert `rst` after E2 alone -> no output; 41 afterward decodes cleanly.
